// File: rtl/afifo_wr_arbiter.sv
// rtl/afifo_wr_arbiter.sv - two-source round-robin burst arbiter feeding an async FIFO write port
// Optional per-source beat statistics are built only when AFIFO_WR_ARB_STAT_EN is defined.
module afifo_wr_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int BURST_LEN  = 16,
    parameter int IDLE_TO    = 8
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  arb_en,
    input  logic                  s0_valid,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s0_last,
    output logic                  s0_ready,
    input  logic                  s1_valid,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic                  s1_last,
    output logic                  s1_ready,
    input  logic                  fifo_wr_vld,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic [1:0]            gnt,
    output logic [31:0]           stat_beats0,
    output logic [31:0]           stat_beats1
);

    typedef enum logic {ST_IDLE, ST_GNT} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [7:0] STALL_MAX = 8'(IDLE_TO - 1);

    state_t      state_q;
    logic [1:0]  gnt_q;
    logic        ptr_q;
    logic [7:0]  beat_cnt_q;
    logic [7:0]  stall_q;

    logic                  in_gnt;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  burst_done;

    // Handshake outputs are gated by reset so nothing is written in the reset cycle.
    always_comb begin
        in_gnt       = (state_q == ST_GNT) && wr_rst_n;
        sel_valid    = gnt_q[1] ? s1_valid : s0_valid;
        sel_last     = gnt_q[1] ? s1_last  : s0_last;
        sel_data     = gnt_q[1] ? s1_data  : s0_data;
        accept       = in_gnt && sel_valid && fifo_wr_vld;
        burst_done   = accept && (sel_last || (beat_cnt_q == LAST_BEAT));
        s0_ready     = in_gnt && gnt_q[0] && fifo_wr_vld;
        s1_ready     = in_gnt && gnt_q[1] && fifo_wr_vld;
        fifo_wr_en   = accept;
        fifo_wr_data = in_gnt ? sel_data : '0;
    end

    assign gnt = gnt_q;

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 2'b00;
            ptr_q      <= 1'b0;
            beat_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_en && (s0_valid || s1_valid)) begin
                        state_q    <= ST_GNT;
                        beat_cnt_q <= '0;
                        stall_q    <= '0;
                        if (s0_valid && s1_valid) begin
                            gnt_q <= ptr_q ? 2'b10 : 2'b01;
                        end else begin
                            gnt_q <= s1_valid ? 2'b10 : 2'b01;
                        end
                    end
                end
                ST_GNT: begin
                    if (accept) begin
                        stall_q <= '0;
                        if (burst_done) begin
                            state_q    <= ST_IDLE;
                            gnt_q      <= 2'b00;
                            ptr_q      <= gnt_q[0];
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end else if (fifo_wr_vld) begin
                        // Only a source stall counts; a FIFO-side stall freezes the timer.
                        if (stall_q == STALL_MAX) begin
                            state_q <= ST_IDLE;
                            gnt_q   <= 2'b00;
                            ptr_q   <= gnt_q[0];
                            stall_q <= '0;
                        end else begin
                            stall_q <= stall_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AFIFO_WR_ARB_STAT_EN
    logic [31:0] stat0_q;
    logic [31:0] stat1_q;

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            if (accept && gnt_q[0] && (stat0_q != 32'hFFFF_FFFF)) stat0_q <= stat0_q + 32'd1;
            if (accept && gnt_q[1] && (stat1_q != 32'hFFFF_FFFF)) stat1_q <= stat1_q + 32'd1;
        end
    end

    assign stat_beats0 = stat0_q;
    assign stat_beats1 = stat1_q;
`else
    assign stat_beats0 = 32'd0;
    assign stat_beats1 = 32'd0;
`endif

endmodule
